tdm_demux16: RTL and testbench
==============================

// Module: tdm_demux16
// PURPOSE
//  1-to-16 time-division demultiplexer: the receive-side counterpart of the 16:1 select path.
//  - Accepts a stream of W-bit samples on one input and steers each sample into one of 16 lane slots.
//  - Presents each completed 16-lane frame on a parallel output with a valid/ready handshake.
//  - Double-buffered: a capture bank fills while the output bank is held for the consumer.
// PARAMETERS
//  W      8   sample width in bits
//  LANES  16  lane count; fixed at 16, taken from package constant NUM_LANES, not overridable
// PORTS
//  clk          in   1     rising-edge clock
//  rst_n        in   1     asynchronous active-low reset
//  din          in   W     input sample
//  din_valid    in   1     din is valid this cycle
//  din_sof      in   1     start of frame; qualified by din_valid
//  din_ready    out  1     block accepts din this cycle
//  din_sel      in   4     target lane; present only when TDM_DEMUX_ADDR_EN is defined
//  frame        out  16*W  lane k occupies bits [k*W +: W]
//  frame_valid  out  1     frame holds a complete frame
//  frame_ready  in   1     consumer accepts frame
//  overrun      out  1     sticky; set when a partial frame is discarded by din_sof
// BEHAVIOUR
//  Reset (rst_n=0, async) clears:
//   - slot=0, capture bank=0, lane mask=0, frame=0, frame_valid=0, overrun=0.
//   - din_ready is 1 in the first cycle after reset release.
//  Accept rule: accept = din_valid & din_ready; a sample is written only on accept.
//  Slot pointer (ADDR_EN undefined):
//   - On accept, din goes to capture[slot], then slot increments; it wraps from 15 to 0.
//   - din_sof on accept forces the write to lane 0 and sets slot=1.
//   - If slot!=0 when din_sof is accepted, the partial frame is discarded and overrun is set.
//  Frame complete: accept into lane 15 (counter mode) -> the capture bank is complete.
//  Hand-off:
//   - If frame_valid=0, or frame_valid & frame_ready in the same cycle, the bank moves to frame
//     on the next edge and frame_valid=1 the next cycle.
//   - Latency: lane-15 accept -> frame_valid is 1 cycle.
//  Stall state machine, states FILL and HOLD:
//   - FILL -> HOLD when the bank is complete and the output bank is occupied and not being taken.
//   - In HOLD, din_ready=0.
//   - HOLD -> FILL on frame_ready & frame_valid; the bank moves to frame on the same edge.
//   - din_ready=1 again the cycle after the move.
//  Output side:
//   - frame and frame_valid are stable while frame_valid & !frame_ready.
//   - frame_valid drops after the handshake unless a new bank moves in on the same edge.
//  Throughput: 16 accepted samples per frame, zero bubbles while the consumer keeps frame_ready=1.
//  Reset mid-frame: the partial capture is lost and any pending frame_valid is dropped immediately.
// CONFIGURATION
//  TDM_DEMUX_ADDR_EN defined:
//   - din_sel port exists; each accepted sample is written to capture[din_sel]; the slot counter is unused.
//   - A 16-bit lane mask records written lanes; rewriting a lane overwrites it, the mask bit stays set.
//   - Frame is complete when the mask reaches 16'hFFFF after an accept.
//   - The mask clears on the move to frame.
//   - din_sof clears the mask; overrun is set if the mask was non-zero.
//  TDM_DEMUX_ADDR_EN undefined: counter-sequenced mode as above; no din_sel port.
// STRUCTURE
//  Package tdm_demux_pkg:
//   - NUM_LANES=16, SEL_W=4.
//   - Typedef lane_sel_t (logic [SEL_W-1:0]).
//   - Enum demux_state_t {FILL, HOLD}.
//   - Constant ALL_LANES=16'hFFFF.
//  Sub-module dec2to4 (2-bit select, enable -> 4 one-hot write enables).
//   - Two-stage tree: one dec2to4 on sel[3:2] enables four dec2to4 on sel[1:0].
//   - Produces the 16 lane write-enables; select bit split is the same as the 16:1 mux.
// TESTING
//  1. Reset, then 16 accepts of din=8'h00..8'h0F with frame_ready=1
//     -> frame_valid=1 one cycle after the 16th accept; frame[k*8+:8]=k.
//  2. frame_ready=0, send 32 samples
//     -> first frame held; din_ready=0 after the second frame's 16th accept;
//     -> raise frame_ready -> second frame appears, din_ready=1 the following cycle.
//  3. 5 samples, then din_sof with din=8'hAA -> overrun=1; next frame lane0=8'hAA,
//     lanes 1..15 carry the 15 samples after the sof.
//  4. Assert rst_n=0 mid-frame and while frame_valid=1
//     -> frame_valid=0 and frame=0 immediately; the next 16 samples form a clean frame.
//  5. ADDR_EN: din_sel order 15..0 with din=8'hF0+sel
//     -> frame_valid after the 16th accept; lane k=8'hF0+k.
//     Repeat lane 3 twice before completion -> last value kept, frame still completes at mask=16'hFFFF.
//  6. Back-to-back frames with frame_ready=1 held -> din_ready never drops; 4 frames in 64+1 cycles.

Source files
------------

// File: rtl/tdm_demux16_pkg.sv
// rtl/tdm_demux16_pkg.sv - shared constants and types for the 1-to-16 TDM demultiplexer
package tdm_demux_pkg;

    localparam int NUM_LANES = 16;
    localparam int SEL_W     = 4;

    localparam logic [NUM_LANES-1:0] ALL_LANES = 16'hFFFF;

    typedef logic [SEL_W-1:0] lane_sel_t;

    // FILL: capture bank accepting samples; HOLD: capture bank complete, waiting for the output bank
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } demux_state_t;

endpackage

// File: rtl/tdm_demux16_if.sv
// rtl/tdm_demux16_if.sv - sample stream in / frame out bundle; din_sel exists only with TDM_DEMUX_ADDR_EN
interface tdm_demux16_if
    import tdm_demux_pkg::*;
#(
    parameter int W = 8
);

    logic [W-1:0]           din;
    logic                   din_valid;
    logic                   din_sof;
    logic                   din_ready;
`ifdef TDM_DEMUX_ADDR_EN
    lane_sel_t              din_sel;
`endif
    logic [NUM_LANES*W-1:0] frame;
    logic                   frame_valid;
    logic                   frame_ready;
    logic                   overrun;

    // Producer of samples and consumer of frames
    modport master (
`ifdef TDM_DEMUX_ADDR_EN
        output din_sel,
`endif
        output din,
        output din_valid,
        output din_sof,
        input  din_ready,
        input  frame,
        input  frame_valid,
        output frame_ready,
        input  overrun
    );

    // The demultiplexer itself
    modport slave (
`ifdef TDM_DEMUX_ADDR_EN
        input  din_sel,
`endif
        input  din,
        input  din_valid,
        input  din_sof,
        output din_ready,
        output frame,
        output frame_valid,
        input  frame_ready,
        output overrun
    );

endinterface

// File: rtl/tdm_demux16_dec2to4.sv
// rtl/tdm_demux16_dec2to4.sv - 2-bit select with enable to 4 one-hot enables, leaf of the lane decode tree
module dec2to4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    // One-hot decode, all zero when disabled
    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux16.sv
// rtl/tdm_demux16.sv - 1-to-16 TDM demux with double-buffered frame output; TDM_DEMUX_ADDR_EN selects addressed lanes
module tdm_demux16
    import tdm_demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux16_if.slave  bus
);

    localparam int FW = NUM_LANES * W;

    demux_state_t         state_q, state_d;
    logic [W-1:0]         cap_q [NUM_LANES];
    logic [W-1:0]         cap_d [NUM_LANES];
    logic [FW-1:0]        frame_q, frame_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 overrun_q, overrun_d;
`ifdef TDM_DEMUX_ADDR_EN
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic [NUM_LANES-1:0] mask_acc;
`else
    lane_sel_t            slot_q, slot_d;
`endif

    logic                 ready;
    logic                 accept;
    logic                 out_free;
    logic                 bank_complete;
    logic                 partial_drop;
    lane_sel_t            wr_lane;
    logic [3:0]           grp_en;
    logic [NUM_LANES-1:0] lane_we;
    logic [FW-1:0]        cap_flat_q;
    logic [FW-1:0]        cap_flat_d;

    assign bus.din_ready   = ready;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.overrun     = overrun_q;

    // Handshake qualification and choice of the lane written by this sample
    always_comb begin
        ready    = (state_q == FILL);
        accept   = bus.din_valid & ready;
        out_free = ~frame_valid_q | bus.frame_ready;
`ifdef TDM_DEMUX_ADDR_EN
        wr_lane  = bus.din_sel;
`else
        wr_lane  = bus.din_sof ? '0 : slot_q;
`endif
    end

    // Two-level decode: upper select bits pick a group of four, lower bits the lane within it
    dec2to4 u_dec_grp (
        .sel (wr_lane[3:2]),
        .en  (accept),
        .y   (grp_en)
    );

    for (genvar g = 0; g < 4; g++) begin : g_dec_lane
        dec2to4 u_dec_lane (
            .sel (wr_lane[1:0]),
            .en  (grp_en[g]),
            .y   (lane_we[g*4 +: 4])
        );
    end

    // Capture bank with this cycle's write applied, plus flat views for the hand-off
    always_comb begin
        cap_d = cap_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_we[k]) begin
                cap_d[k] = bus.din;
            end
        end
        cap_flat_q = '0;
        cap_flat_d = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            cap_flat_q[k*W +: W] = cap_q[k];
            cap_flat_d[k*W +: W] = cap_d[k];
        end
    end

    // Frame completion and partial-frame discard detection
    always_comb begin
`ifdef TDM_DEMUX_ADDR_EN
        mask_acc      = (bus.din_sof ? '0 : mask_q) | lane_we;
        bank_complete = accept & (mask_acc == ALL_LANES);
        partial_drop  = accept & bus.din_sof & (mask_q != '0);
`else
        // A sof write always lands in lane 0, so lane 15 is only reached by the counter
        bank_complete = lane_we[NUM_LANES-1];
        partial_drop  = accept & bus.din_sof & (slot_q != '0);
`endif
    end

    // FILL/HOLD next state, lane tracking and output bank hand-off
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q & ~bus.frame_ready;
        overrun_d     = overrun_q | partial_drop;
`ifdef TDM_DEMUX_ADDR_EN
        mask_d        = accept ? mask_acc : mask_q;
`else
        slot_d        = slot_q;
        if (accept) begin
            slot_d = bus.din_sof ? lane_sel_t'(1) : slot_q + lane_sel_t'(1);
        end
`endif

        case (state_q)
            FILL: begin
                if (bank_complete) begin
                    if (out_free) begin
                        frame_d       = cap_flat_d;
                        frame_valid_d = 1'b1;
`ifdef TDM_DEMUX_ADDR_EN
                        mask_d        = '0;
`endif
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (frame_valid_q & bus.frame_ready) begin
                    frame_d       = cap_flat_q;
                    frame_valid_d = 1'b1;
                    state_d       = FILL;
`ifdef TDM_DEMUX_ADDR_EN
                    mask_d        = '0;
`endif
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State, capture and output registers; reset drops any pending frame at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) begin
                cap_q[k] <= '0;
            end
`ifdef TDM_DEMUX_ADDR_EN
            mask_q        <= '0;
`else
            slot_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            cap_q         <= cap_d;
`ifdef TDM_DEMUX_ADDR_EN
            mask_q        <= mask_d;
`else
            slot_q        <= slot_d;
`endif
        end
    end

endmodule

// File: tb/tb_tdm_demux16.sv
// tb/tb_tdm_demux16.sv - self-checking bench for tdm_demux16 (counter mode; addressed mode with TDM_DEMUX_ADDR_EN)
module tb_tdm_demux16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tdm_demux16_if #(.W(8)) bus ();

    tdm_demux16 #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       exp_ovr;
    } vec_t;

    int           n_vec = 0;
    int           n_miss = 0;
    logic [127:0] exp_q[$];
    logic [7:0]   m_cap [16];
    int           m_slot = 0;
    logic [15:0]  m_mask = '0;
    logic         m_ovr = 1'b0;
    int           stalls = 0;
    int           popped = 0;
    int           cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame();
        logic [127:0] f;
        for (int k = 0; k < 16; k++) f[k*8 +: 8] = m_cap[k];
        exp_q.push_back(f);
    endtask

    task automatic model_accept(input logic [7:0] d, input int sel, input logic sof);
`ifdef TDM_DEMUX_ADDR_EN
        if (sof) begin
            if (m_mask != 0) m_ovr = 1'b1;
            m_mask = '0;
        end
        m_cap[sel]  = d;
        m_mask[sel] = 1'b1;
        m_slot      = sof ? 1 : (m_slot + 1) % 16;
        if (m_mask == 16'hFFFF) begin
            push_frame();
            m_mask = '0;
        end
`else
        if (sof) begin
            if (m_slot != 0) m_ovr = 1'b1;
            m_slot = 0;
        end
        m_cap[m_slot] = d;
        if (m_slot == 15 && sel >= 0) push_frame();
        m_slot = (m_slot + 1) % 16;
`endif
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called aligned to posedge+1; returns aligned to posedge+1 after the accepting edge
    task automatic send_sel(input logic [7:0] d, input int sel, input logic sof);
        int n = 0;
        bus.din       = d;
        bus.din_valid = 1'b1;
        bus.din_sof   = sof;
`ifdef TDM_DEMUX_ADDR_EN
        bus.din_sel   = sel[3:0];
`endif
        @(negedge clk);
        while (!bus.din_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        stalls += n;
        if (!bus.din_ready) check("din_ready_timeout", {127'd0, bus.din_ready}, 128'd1);
        else model_accept(d, sel, sof);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.din_sof   = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic sof);
        send_sel(d, sof ? 0 : m_slot, sof);
    endtask

    task automatic model_reset();
        m_slot = 0;
        m_mask = '0;
        m_ovr  = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 16; k++) m_cap[k] = '0;
    endtask

    // Scoreboard: every frame handshake pops the oldest expected frame
    always @(negedge clk) begin
        if (rst_n && bus.frame_valid && bus.frame_ready) begin
            check("frame_queue_nonempty", {127'd0, exp_q.size() > 0}, 128'd1);
            if (exp_q.size() > 0) begin
                check("frame", bus.frame, exp_q.pop_front());
                popped++;
            end
        end
    end

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [21];
        logic [127:0] f_exp;
        int           p0;
        int           c0;
        int           n;

        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.din_sof = 1'b0;
        bus.frame_ready = 1'b0;
`ifdef TDM_DEMUX_ADDR_EN
        bus.din_sel = '0;
`endif
        model_reset();

        for (int i = 0; i < 21; i++) begin
            if (i < 5) begin
                tbl[i] = '{8'h30 + 8'(i), 1'b0, 1'b0};
            end else if (i == 5) begin
                tbl[i] = '{8'hAA, 1'b1, 1'b1};
            end else begin
                tbl[i] = '{8'h50 + 8'(i - 6), 1'b0, 1'b1};
            end
        end

        // Reset state
        #12;
        check("rst_frame_valid", {127'd0, bus.frame_valid}, 128'd0);
        check("rst_frame", bus.frame, 128'd0);
        check("rst_overrun", {127'd0, bus.overrun}, 128'd0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_din_ready", {127'd0, bus.din_ready}, 128'd1);
        sync();

        // Test 1: one frame 00..0F, one-cycle latency
        bus.frame_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        @(negedge clk);
        check("t1_frame_valid", {127'd0, bus.frame_valid}, 128'd1);
        for (int k = 0; k < 16; k++) f_exp[k*8 +: 8] = 8'(k);
        check("t1_frame_lanes", bus.frame, f_exp);
        sync();

        // Test 2: consumer stalled for two frames
        bus.frame_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(8'h60 + 8'(i), 1'b0);
        @(negedge clk);
        check("t2_din_ready_low", {127'd0, bus.din_ready}, 128'd0);
        check("t2_frame_valid", {127'd0, bus.frame_valid}, 128'd1);
        check("t2_held_frame", bus.frame, exp_q.size() > 0 ? exp_q[0] : 128'd1);
        repeat (3) @(negedge clk);
        check("t2_frame_stable", bus.frame, exp_q.size() > 0 ? exp_q[0] : 128'd1);
        check("t2_still_stalled", {127'd0, bus.din_ready}, 128'd0);
        sync();
        bus.frame_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_din_ready_back", {127'd0, bus.din_ready}, 128'd1);
        @(negedge clk);
        check("t2_valid_dropped", {127'd0, bus.frame_valid}, 128'd0);
        check("t2_queue_drained", 128'(exp_q.size()), 128'd0);
        sync();

        // Test 3: table of samples with a mid-frame sof
        for (int i = 0; i < 21; i++) begin
            send(tbl[i].d, tbl[i].sof);
            check($sformatf("t3_overrun_%0d", i), {127'd0, bus.overrun}, {127'd0, tbl[i].exp_ovr});
        end
        @(negedge clk);
        check("t3_lane0", {120'd0, bus.frame[7:0]}, 128'hAA);
        check("t3_lane1", {120'd0, bus.frame[15:8]}, 128'h50);
        check("t3_lane15", {120'd0, bus.frame[127:120]}, 128'h5E);
        sync();

        // Test 4: reset with a pending frame and a partial capture
        bus.frame_ready = 1'b0;
        for (int i = 0; i < 21; i++) send(8'h90 + 8'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_valid_cleared", {127'd0, bus.frame_valid}, 128'd0);
        check("t4_frame_cleared", bus.frame, 128'd0);
        check("t4_overrun_cleared", {127'd0, bus.overrun}, 128'd0);
        model_reset();
        sync();
        rst_n = 1'b1;
        bus.frame_ready = 1'b1;
        p0 = popped;
        for (int i = 0; i < 16; i++) send(8'hC0 + 8'(i), 1'b0);
        @(negedge clk);
        check("t4_clean_frame_valid", {127'd0, bus.frame_valid}, 128'd1);
        for (int k = 0; k < 16; k++) f_exp[k*8 +: 8] = 8'hC0 + 8'(k);
        check("t4_clean_frame", bus.frame, f_exp);
        sync();
        check("t4_popped", 128'(popped - p0), 128'd1);

`ifdef TDM_DEMUX_ADDR_EN
        // Test 5: addressed lanes in reverse order, then a repeated lane
        for (int s = 15; s >= 0; s--) send_sel(8'hF0 + 8'(s), s, 1'b0);
        @(negedge clk);
        check("t5_frame_valid", {127'd0, bus.frame_valid}, 128'd1);
        for (int k = 0; k < 16; k++) f_exp[k*8 +: 8] = 8'hF0 + 8'(k);
        check("t5_frame_rev", bus.frame, f_exp);
        sync();
        send_sel(8'hEE, 3, 1'b0);
        for (int s = 0; s < 15; s++) send_sel(8'h10 + 8'(s), s, 1'b0);
        check("t5_not_complete", {127'd0, bus.frame_valid}, 128'd0);
        send_sel(8'h1F, 15, 1'b0);
        @(negedge clk);
        check("t5_rewrite_valid", {127'd0, bus.frame_valid}, 128'd1);
        check("t5_lane3_last", {120'd0, bus.frame[31:24]}, 128'h13);
        m_slot = 0;
        sync();
`endif

        // Test 6: four back-to-back frames with the consumer always ready
        bus.frame_ready = 1'b1;
        stalls = 0;
        p0 = popped;
        c0 = cyc;
        for (int i = 0; i < 64; i++) send(8'(i * 3), 1'b0);
        n = 0;
        while (popped - p0 < 4 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t6_no_stalls", 128'(stalls), 128'd0);
        check("t6_frames", 128'(popped - p0), 128'd4);
        check("t6_cycles", {127'd0, (cyc - c0) <= 65}, 128'd1);
        check("t6_queue_drained", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
